// File: rtl/mux4_strobe.sv
// One 4:1 data-selector section with an active-low strobe, bitwise over DATA_W.
// Latency: zero, purely combinational.
// Backpressure: none; the output follows the inputs continuously.
//
// Ports:
//   b, a    select MSB/LSB; {b,a} = 00..11 picks c0..c3
//   g_n     strobe, active low; high forces y to all zeros
//   c0..c3  data candidates, DATA_W bits each
//   y       selected data, or zero while the strobe is high
module mux4_strobe #(
  parameter int DATA_W = 1
) (
  input  logic              b,
  input  logic              a,
  input  logic              g_n,
  input  logic [DATA_W-1:0] c0,
  input  logic [DATA_W-1:0] c1,
  input  logic [DATA_W-1:0] c2,
  input  logic [DATA_W-1:0] c3,
  output logic [DATA_W-1:0] y
);

  logic [DATA_W-1:0] lo_pair;
  logic [DATA_W-1:0] hi_pair;
  logic [DATA_W-1:0] sel_dat;

  // Conditional operators rather than a case statement: when a select bit is
  // unknown, simulation merges the two arms bit by bit, so equal candidates
  // still produce a known value and differing ones produce X, as the part does.
  assign lo_pair = a ? c1 : c0;
  assign hi_pair = a ? c3 : c2;
  assign sel_dat = b ? hi_pair : lo_pair;

  // Same merging for an unknown strobe: a selected 0 stays 0, anything else is X.
  assign y = g_n ? {DATA_W{1'b0}} : sel_dat;

endmodule

// File: rtl/sn54ls153.sv
// Dual 4:1 data selector (54LS153 behaviour) with a registered copy of each output.
// Latency: o_1Y/o_2Y zero; o_1Y_q/o_2Y_q one i_clk cycle.
// Backpressure: none; no handshake, registers load every rising edge.
//
// Ports:
//   i_clk, i_rst      clock and async active-high reset for the registered outputs only
//   i_B, i_A          shared select, {B,A} = 00..11 picks Cn0..Cn3
//   i_1G, i_2G        per-section strobes, active low
//   i_1C0..i_1C3      section-1 data
//   i_2C0..i_2C3      section-2 data
//   o_1Y, o_2Y        combinational section outputs
//   o_1Y_q, o_2Y_q    registered section outputs, reset to RST_VAL
module sn54ls153 #(
  parameter int   DATA_W  = 1,
  parameter logic RST_VAL = 1'b0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_B,
  input  logic              i_A,
  input  logic              i_1G,
  input  logic              i_2G,
  input  logic [DATA_W-1:0] i_1C0,
  input  logic [DATA_W-1:0] i_1C1,
  input  logic [DATA_W-1:0] i_1C2,
  input  logic [DATA_W-1:0] i_1C3,
  input  logic [DATA_W-1:0] i_2C0,
  input  logic [DATA_W-1:0] i_2C1,
  input  logic [DATA_W-1:0] i_2C2,
  input  logic [DATA_W-1:0] i_2C3,
  output logic [DATA_W-1:0] o_1Y,
  output logic [DATA_W-1:0] o_2Y,
  output logic [DATA_W-1:0] o_1Y_q,
  output logic [DATA_W-1:0] o_2Y_q
);

  mux4_strobe #(.DATA_W(DATA_W)) u_sec1 (
    .b   (i_B),
    .a   (i_A),
    .g_n (i_1G),
    .c0  (i_1C0),
    .c1  (i_1C1),
    .c2  (i_1C2),
    .c3  (i_1C3),
    .y   (o_1Y)
  );

  mux4_strobe #(.DATA_W(DATA_W)) u_sec2 (
    .b   (i_B),
    .a   (i_A),
    .g_n (i_2G),
    .c0  (i_2C0),
    .c1  (i_2C1),
    .c2  (i_2C2),
    .c3  (i_2C3),
    .y   (o_2Y)
  );

  // Reset is asynchronous and has priority over a coincident clock edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_1Y_q <= {DATA_W{RST_VAL}};
      o_2Y_q <= {DATA_W{RST_VAL}};
    end else begin
      o_1Y_q <= o_1Y;
      o_2Y_q <= o_2Y;
    end
  end

endmodule

// File: tb/tb_sn54ls153.sv
// Self-checking bench for sn54ls153 (DATA_W = 1).
// Latency: combinational outputs checked 1 time unit after drive, registered ones after an edge.
// Backpressure: none.
module tb_sn54ls153;

  localparam int W = 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         b   = 1'b0;
  logic         a   = 1'b0;
  logic         g1  = 1'b1;
  logic         g2  = 1'b1;
  logic [W-1:0] c1 [4];
  logic [W-1:0] c2 [4];
  logic [W-1:0] y1, y2, y1_q, y2_q;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [W-1:0] y1;
    logic [W-1:0] y2;
  } exp_t;

  exp_t sb[$];
  exp_t rsb[$];

  always #5 clk = ~clk;

  sn54ls153 #(.DATA_W(W), .RST_VAL(1'b0)) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_B    (b),
    .i_A    (a),
    .i_1G   (g1),
    .i_2G   (g2),
    .i_1C0  (c1[0]),
    .i_1C1  (c1[1]),
    .i_1C2  (c1[2]),
    .i_1C3  (c1[3]),
    .i_2C0  (c2[0]),
    .i_2C1  (c2[1]),
    .i_2C2  (c2[2]),
    .i_2C3  (c2[3]),
    .o_1Y   (y1),
    .o_2Y   (y2),
    .o_1Y_q (y1_q),
    .o_2Y_q (y2_q)
  );

  // Truth-table reference: strobe high gives 0, otherwise data bit indexed by {B,A}.
  function automatic logic [W-1:0] ref_mux(input logic g, input logic [1:0] s,
                                           input logic [3:0] d);
    if (g) return '0;
    return {W{d[s]}};
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one vector and push the expected combinational outputs.
  task automatic apply(input logic g1v, input logic g2v, input logic [1:0] s,
                       input logic [3:0] d1, input logic [3:0] d2);
    exp_t e;
    g1 = g1v;
    g2 = g2v;
    b  = s[1];
    a  = s[0];
    for (int k = 0; k < 4; k++) begin
      c1[k] = {W{d1[k]}};
      c2[k] = {W{d2[k]}};
    end
    e.y1 = ref_mux(g1v, s, d1);
    e.y2 = ref_mux(g2v, s, d2);
    sb.push_back(e);
  endtask

  // Let the combinational path settle, then pop and compare; the popped
  // expectation is also returned for the registered-path checks.
  task automatic settle_check(input string tag, output exp_t e);
    #1;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s observed=empty_queue expected=entry", tag);
      e = '0;
    end else begin
      e = sb.pop_front();
      chk({tag, "_y1"}, y1, e.y1);
      chk({tag, "_y2"}, y2, e.y2);
    end
  endtask

  task automatic reg_check(input string tag);
    exp_t e;
    if (rsb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s observed=empty_queue expected=entry", tag);
    end else begin
      e = rsb.pop_front();
      chk({tag, "_q1"}, y1_q, e.y1);
      chk({tag, "_q2"}, y2_q, e.y2);
    end
  endtask

  initial begin
    exp_t e;
    logic [11:0] v;
    logic [3:0]  oh;

    for (int k = 0; k < 4; k++) begin
      c1[k] = '0;
      c2[k] = '0;
    end

    // Reset held: registers at RST_VAL even across clock edges.
    #2;
    chk("rst_q1", y1_q, 1'b0);
    chk("rst_q2", y2_q, 1'b0);
    @(posedge clk);
    #1;
    chk("rst_hold_q1", y1_q, 1'b0);

    // Strobe disabled forces zero regardless of data (reset still high: comb path unaffected).
    apply(1'b1, 1'b1, 2'b00, 4'b0000, 4'b0000);
    settle_check("strobe_off_0000", e);
    apply(1'b1, 1'b1, 2'b00, 4'b1111, 4'b1111);
    settle_check("strobe_off_1111", e);

    // One-hot on the selected input gives 1; one-hot elsewhere gives 0.
    for (int i = 0; i < 4; i++) begin
      oh = 4'b0001 << i;
      apply(1'b0, 1'b1, 2'(i), oh, 4'b0000);
      settle_check($sformatf("sel%0d_hit", i), e);
      oh = 4'b0001 << ((i + 1) % 4);
      apply(1'b0, 1'b1, 2'(i), oh, 4'b0000);
      settle_check($sformatf("sel%0d_miss", i), e);
    end

    // Section independence: section 2 selects C2 while section 1 is disabled.
    apply(1'b1, 1'b0, 2'b10, 4'b1111, 4'b0100);
    settle_check("indep_g1_off", e);
    apply(1'b0, 1'b0, 2'b10, 4'b1111, 4'b0100);
    settle_check("indep_g1_on", e);
    apply(1'b1, 1'b0, 2'b10, 4'b1111, 4'b0100);
    settle_check("indep_g1_off_again", e);

    // Exhaustive sweep: {G1,G2,B,A,1C3..1C0,2C3..2C0}.
    for (int n = 0; n < 4096; n++) begin
      v = 12'(n);
      apply(v[11], v[10], v[9:8], v[7:4], v[3:0]);
      settle_check($sformatf("sweep_%03h", v), e);
    end

    chk("rst_after_sweep_q1", y1_q, 1'b0);
    chk("rst_after_sweep_q2", y2_q, 1'b0);

    // Registered path.
    @(negedge clk);
    rst = 1'b0;
    apply(1'b0, 1'b1, 2'b11, 4'b1000, 4'b0000);
    settle_check("reg_v1_comb", e);
    rsb.push_back(e);
    chk("reg_before_edge_q1", y1_q, 1'b0);
    @(posedge clk);
    #1;
    reg_check("reg_v1");

    @(negedge clk);
    apply(1'b1, 1'b0, 2'b00, 4'b1111, 4'b0001);
    settle_check("reg_v2_comb", e);
    rsb.push_back(e);
    @(posedge clk);
    #1;
    reg_check("reg_v2");

    @(negedge clk);
    apply(1'b0, 1'b0, 2'b11, 4'b1000, 4'b1000);
    settle_check("reg_v3_comb", e);
    rsb.push_back(e);
    @(posedge clk);
    #1;
    reg_check("reg_v3");

    // Mid-cycle reset clears the registers at once but leaves the comb outputs alone.
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("async_rst_q1", y1_q, 1'b0);
    chk("async_rst_q2", y2_q, 1'b0);
    chk("async_rst_y1", y1, 1'b1);
    chk("async_rst_y2", y2, 1'b1);
    @(posedge clk);
    #1;
    chk("rst_held_edge_q1", y1_q, 1'b0);

    // First edge after release reloads the current outputs.
    @(negedge clk);
    rst = 1'b0;
    rsb.push_back(e);
    @(posedge clk);
    #1;
    reg_check("reg_after_release");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
